// File: rtl/dvvm_pkg.sv
// dvvm_pkg: shared state encoding and datapath widths for the Wallace-tree chunk sequencer
//   TERM_W     : width of one term / one tree input slot
//   TREE_OUT_W : width of the tree's partial-sum output
//   state_t    : sequencer FSM states
package dvvm_pkg;
    localparam int TERM_W     = 16;
    localparam int TREE_OUT_W = 32;
    typedef enum logic [2:0] {IDLE, FILL, ISSUE, WAIT, DONE} state_t;
endpackage

// File: rtl/wt_chunk_sequencer_if.sv
// wt_chunk_sequencer_if: job, term, tree and result handshakes of the chunk sequencer
//   job_valid/job_ready/job_len        : job request
//   t_valid/t_ready/t_data             : term stream
//   wt_in_valid/wt_in_ready/wt_in_flat : chunk to tree (slot k at [16k+15:16k])
//   wt_out_valid/wt_out                : tree partial-sum pulse
//   res_valid/res_ready/res_data/res_chunks : job result
//   err                                : sticky stray tree result flag
//   slave = sequencer view, master = environment view
interface wt_chunk_sequencer_if
    import dvvm_pkg::*;
#(parameter int N = 4, parameter int LEN_W = 8, parameter int ACC_W = 32);
    logic                    job_valid, job_ready;
    logic [LEN_W-1:0]        job_len;
    logic                    t_valid, t_ready;
    logic [TERM_W-1:0]       t_data;
    logic                    wt_in_valid, wt_in_ready;
    logic [N*TERM_W-1:0]     wt_in_flat;
    logic                    wt_out_valid;
    logic [TREE_OUT_W-1:0]   wt_out;
    logic                    res_valid, res_ready;
    logic [ACC_W-1:0]        res_data;
    logic [LEN_W-1:0]        res_chunks;
    logic                    err;
    modport slave (
        input  job_valid, job_len, t_valid, t_data, wt_in_ready, wt_out_valid, wt_out, res_ready,
        output job_ready, t_ready, wt_in_valid, wt_in_flat, res_valid, res_data, res_chunks, err
    );
    modport master (
        output job_valid, job_len, t_valid, t_data, wt_in_ready, wt_out_valid, wt_out, res_ready,
        input  job_ready, t_ready, wt_in_valid, wt_in_flat, res_valid, res_data, res_chunks, err
    );
endinterface

// File: rtl/wt_chunk_packer.sv
// wt_chunk_packer: staging register that packs terms into an N-slot zero-padded chunk
//   clk, rst      : clock, async active-low reset
//   clr           : empty the staging register and restart at slot 0
//   wr, din       : write din into the next free slot
//   remaining     : terms left in the job before this write
//   chunk_end     : this write fills the chunk or is the job's last term
//   flat          : staged chunk, slot k at [16k+15:16k]
module wt_chunk_packer
    import dvvm_pkg::*;
#(parameter int N = 4, parameter int LEN_W = 8) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                wr,
    input  logic [TERM_W-1:0]   din,
    input  logic [LEN_W-1:0]    remaining,
    output logic                chunk_end,
    output logic [N*TERM_W-1:0] flat
);
    localparam int IW = N > 1 ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);
    logic [N-1:0][TERM_W-1:0] stg;
    logic [CW-1:0]            fill_cnt;
    assign chunk_end = wr && (fill_cnt == CW'(N - 1) || remaining == LEN_W'(1));
    assign flat = stg;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            stg      <= '0;
            fill_cnt <= '0;
        end else if (clr) begin
            stg      <= '0;
            fill_cnt <= '0;
        end else if (wr) begin
            stg[fill_cnt[IW-1:0]] <= din;
            fill_cnt              <= fill_cnt + CW'(1);
        end
endmodule

// File: rtl/wt_chunk_sequencer.sv
// wt_chunk_sequencer: feeds term streams to a shared N-input Wallace tree chunk by chunk and accumulates the partial sums
//   clk, rst : clock, async active-low reset
//   bus      : job / term / tree / result handshakes (slave view)
module wt_chunk_sequencer
    import dvvm_pkg::*;
#(parameter int N = 4, parameter int LEN_W = 8, parameter int ACC_W = 32) (
    input logic                  clk,
    input logic                  rst,
    wt_chunk_sequencer_if.slave  bus
);
    state_t           state;
    logic [LEN_W-1:0] remaining, chunks;
    logic [ACC_W-1:0] acc;
    logic             job_ready, t_ready, wt_in_valid, res_valid, err;
    logic             beat, chunk_end, clr;
    assign beat = t_ready && bus.t_valid;
    // staging restarts on job accept and after every non-final tree result
    assign clr  = (state == IDLE && bus.job_valid) || (state == WAIT && bus.wt_out_valid && remaining != '0);
    wt_chunk_packer #(.N(N), .LEN_W(LEN_W)) u_packer (
        .clk(clk), .rst(rst), .clr(clr), .wr(beat), .din(bus.t_data),
        .remaining(remaining), .chunk_end(chunk_end), .flat(bus.wt_in_flat)
    );
    assign bus.job_ready   = job_ready;
    assign bus.t_ready     = t_ready;
    assign bus.wt_in_valid = wt_in_valid;
    assign bus.res_valid   = res_valid;
    assign bus.res_data    = acc;
    assign bus.res_chunks  = chunks;
    assign bus.err         = err;
    // handshake outputs are flops updated together with the state
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state       <= IDLE;
            remaining   <= '0;
            chunks      <= '0;
            acc         <= '0;
            err         <= 1'b0;
            job_ready   <= 1'b1;
            t_ready     <= 1'b0;
            wt_in_valid <= 1'b0;
            res_valid   <= 1'b0;
        end else begin
            if (bus.wt_out_valid && state != WAIT) err <= 1'b1;
            case (state)
                IDLE: if (bus.job_valid) begin
                    remaining <= bus.job_len;
                    acc       <= '0;
                    chunks    <= '0;
                    job_ready <= 1'b0;
                    state     <= bus.job_len == '0 ? DONE : FILL;
                    res_valid <= bus.job_len == '0;
                    t_ready   <= bus.job_len != '0;
                end
                FILL: if (beat) begin
                    remaining <= remaining - LEN_W'(1);
                    if (chunk_end) begin
                        state       <= ISSUE;
                        t_ready     <= 1'b0;
                        wt_in_valid <= 1'b1;
                    end
                end
                ISSUE: if (bus.wt_in_ready) begin
                    chunks      <= chunks + LEN_W'(1);
                    wt_in_valid <= 1'b0;
                    state       <= WAIT;
                end
                WAIT: if (bus.wt_out_valid) begin
                    acc       <= acc + ACC_W'(bus.wt_out);
                    state     <= remaining == '0 ? DONE : FILL;
                    res_valid <= remaining == '0;
                    t_ready   <= remaining != '0;
                end
                DONE: if (bus.res_ready) begin
                    res_valid <= 1'b0;
                    job_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_wt_chunk_sequencer.sv
// tb_wt_chunk_sequencer: randomized and directed checks of wt_chunk_sequencer against a term-list reference model
module tb_wt_chunk_sequencer;
    localparam int N = 4, LEN_W = 8, ACC_W = 32;
    logic clk = 1'b0, rst = 1'b0;
    int total = 0, bad = 0;
    int n_xfer = 0, n_vcyc = 0;
    logic err_exp = 1'b0;
    logic [15:0] terms[$];

    always #5 clk = ~clk;

    wt_chunk_sequencer_if #(.N(N), .LEN_W(LEN_W), .ACC_W(ACC_W)) bus();
    wt_chunk_sequencer #(.N(N), .LEN_W(LEN_W), .ACC_W(ACC_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always @(posedge clk) begin
        if (bus.wt_in_valid) n_vcyc <= n_vcyc + 1;
        if (bus.wt_in_valid && bus.wt_in_ready) n_xfer <= n_xfer + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one job from the terms queue, acting as producer, tree and consumer.
    task automatic run_job(input int gap_max, input int in_stall, input int res_stall,
                           input int lat_max, input bit rand_out);
        int len = terms.size();
        int nch = (len + N - 1) / N;
        int x0 = n_xfer, v0 = n_vcyc;
        logic [ACC_W-1:0] acc = '0;
        logic [N*16-1:0] flat_exp;
        logic [31:0] out;
        check("job_ready_idle", bus.job_ready, 1);
        bus.job_valid = 1'b1;
        bus.job_len = LEN_W'(len);
        tick;
        bus.job_valid = 1'b0;
        for (int c = 0; c < nch; c++) begin
            flat_exp = '0;
            for (int k = 0; k < N && c * N + k < len; k++) begin
                repeat ($urandom_range(gap_max, 0)) begin
                    bus.t_data = 16'($urandom);
                    tick;
                end
                bus.t_valid = 1'b1;
                bus.t_data = terms[c * N + k];
                check("t_ready", bus.t_ready, 1);
                flat_exp[16 * k +: 16] = terms[c * N + k];
                tick;
                bus.t_valid = 1'b0;
            end
            check("in_valid", bus.wt_in_valid, 1);
            check("in_flat", bus.wt_in_flat, flat_exp);
            for (int i = 0; i < in_stall; i++) begin
                tick;
                check("in_valid_hold", bus.wt_in_valid, 1);
                check("in_flat_hold", bus.wt_in_flat, flat_exp);
            end
            bus.wt_in_ready = 1'b1;
            tick;
            bus.wt_in_ready = 1'b0;
            check("in_valid_drop", bus.wt_in_valid, 0);
            repeat ($urandom_range(lat_max, 0)) tick;
            out = '0;
            for (int k = 0; k < N; k++) out += 32'(flat_exp[16 * k +: 16]);
            if (rand_out) out = $urandom;
            acc += ACC_W'(out);
            bus.wt_out_valid = 1'b1;
            bus.wt_out = out;
            tick;
            bus.wt_out_valid = 1'b0;
        end
        check("res_valid", bus.res_valid, 1);
        check("res_data", bus.res_data, acc);
        check("res_chunks", bus.res_chunks, nch);
        check("err", bus.err, err_exp);
        check("xfers", n_xfer - x0, nch);
        if (len == 0) check("no_in_valid", n_vcyc - v0, 0);
        for (int i = 0; i < res_stall; i++) begin
            bus.res_ready = 1'b0;
            tick;
            check("res_valid_hold", bus.res_valid, 1);
            check("res_data_hold", bus.res_data, acc);
        end
        bus.res_ready = 1'b1;
        tick;
        bus.res_ready = 1'b0;
        check("res_valid_drop", bus.res_valid, 0);
        check("job_ready_back", bus.job_ready, 1);
    endtask

    task automatic check_reset_outputs;
        check("rst_job_ready", bus.job_ready, 1);
        check("rst_t_ready", bus.t_ready, 0);
        check("rst_in_valid", bus.wt_in_valid, 0);
        check("rst_in_flat", bus.wt_in_flat, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_res_chunks", bus.res_chunks, 0);
        check("rst_err", bus.err, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bus.job_valid = 0; bus.job_len = 0; bus.t_valid = 0; bus.t_data = 0;
        bus.wt_in_ready = 0; bus.wt_out_valid = 0; bus.wt_out = 0; bus.res_ready = 0;
        #12;
        check_reset_outputs();
        rst = 1'b1;
        tick;
        terms = {16'd5, 16'd10, 16'd20, 16'd30};
        run_job(0, 0, 0, 0, 0);
        terms = {};
        run_job(0, 0, 0, 0, 0);
        terms = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
        run_job(0, 0, 0, 2, 0);
        terms = {};
        for (int i = 0; i < 8; i++) terms.push_back(16'hFFFF);
        run_job(0, 0, 0, 1, 0);
        terms = {16'd7, 16'd100, 16'd3, 16'd9, 16'd11};
        run_job(3, 3, 5, 3, 0);
        for (int j = 0; j < 25; j++) begin
            terms = {};
            repeat ($urandom_range(21, 0)) terms.push_back(16'($urandom));
            run_job($urandom_range(2, 0), $urandom_range(3, 0), $urandom_range(3, 0), 4, 1'($urandom));
        end
        terms = {};
        repeat (255) terms.push_back(16'($urandom));
        run_job(0, 0, 0, 0, 1);
        bus.job_valid = 1'b1;
        bus.job_len = LEN_W'(4);
        tick;
        bus.job_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.t_valid = 1'b1;
            bus.t_data = 16'(k + 1);
            tick;
        end
        bus.t_valid = 1'b0;
        check("pre_rst_in_valid", bus.wt_in_valid, 1);
        bus.wt_in_ready = 1'b1;
        tick;
        bus.wt_in_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_reset_outputs();
        rst = 1'b1;
        tick;
        bus.wt_out_valid = 1'b1;
        bus.wt_out = 32'd12345;
        tick;
        bus.wt_out_valid = 1'b0;
        check("stray_err", bus.err, 1);
        check("stray_acc", bus.res_data, 0);
        check("stray_job_ready", bus.job_ready, 1);
        err_exp = 1'b1;
        terms = {16'd40, 16'd2};
        run_job(1, 1, 1, 1, 0);
        rst = 1'b0;
        #1;
        check("err_cleared", bus.err, 0);
        rst = 1'b1;
        tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
